// File: rtl/rename_pkg.sv
// Shared rename-stage types and default sizing for the register alias table.
package rename_pkg;
  localparam int ARCH_REGS_D = 32;
  localparam int PHYS_REGS_D = 64;
  localparam int DW_D        = 2;
  localparam int WB_D        = 4;
  localparam int NCKPT_D     = 4;

  typedef logic [$clog2(PHYS_REGS_D)-1:0] phys_tag_t;
  typedef logic [$clog2(ARCH_REGS_D)-1:0] arch_idx_t;
  typedef logic [$clog2(NCKPT_D)-1:0]     ckpt_id_t;
  typedef struct packed { phys_tag_t phys; } map_entry_t;
endpackage

// File: rtl/rat_ckpt_store.sv
// Circular queue of full-map branch checkpoints with head/tail/count bookkeeping.
module rat_ckpt_store
  import rename_pkg::*;
#(
  parameter int ARCH_REGS = ARCH_REGS_D,
  parameter int PHYS_REGS = PHYS_REGS_D,
  parameter int NUM_CKPT  = NCKPT_D,
  localparam int PW = $clog2(PHYS_REGS),
  localparam int CW = $clog2(NUM_CKPT)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          i_flush,
  input  logic                          i_wr_en,
  input  logic [ARCH_REGS-1:0][PW-1:0]  i_wr_map,
  input  logic                          i_commit,
  input  logic                          i_restore,
  input  logic [CW-1:0]                 i_restore_id,
  output logic [ARCH_REGS-1:0][PW-1:0]  o_rd_map,
  output logic [CW-1:0]                 o_tail,
  output logic [CW:0]                   o_count
);
  logic [NUM_CKPT-1:0][ARCH_REGS-1:0][PW-1:0] r_ckpt;
  logic [CW-1:0] r_head, r_tail;
  logic [CW:0]   r_count;
  logic          w_commit;
  logic [CW:0]   w_span;

  assign w_commit = i_commit && (r_count != '0);
  // Live entries from the current head through the restored id, inclusive.
  assign w_span   = {1'b0, i_restore_id - r_head} + (CW+1)'(1);
  assign o_rd_map = r_ckpt[i_restore_id];
  assign o_tail   = r_tail;
  assign o_count  = r_count;

  always_ff @(posedge clock) begin
    if (reset || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_restore) begin
      r_tail  <= i_restore_id + CW'(1);
      r_head  <= r_head + CW'(w_commit);
      r_count <= w_span - (CW+1)'(w_commit);
    end else begin
      if (i_wr_en) r_tail <= r_tail + CW'(1);
      r_head  <= r_head + CW'(w_commit);
      r_count <= r_count + (CW+1)'(i_wr_en) - (CW+1)'(w_commit);
    end
  end

  always_ff @(posedge clock) begin
    if (i_wr_en) r_ckpt[r_tail] <= i_wr_map;
  end
endmodule

// File: rtl/rat_ckpt.sv
// Superscalar rename map with intra-group bypass, per-tag ready bits and internal branch checkpoints.
module rat_ckpt
  import rename_pkg::*;
#(
  parameter int ARCH_REGS      = ARCH_REGS_D,
  parameter int PHYS_REGS      = PHYS_REGS_D,
  parameter int DISPATCH_WIDTH = DW_D,
  parameter int WB_WIDTH       = WB_D,
  parameter int NUM_CKPT       = NCKPT_D,
  localparam int AW = $clog2(ARCH_REGS),
  localparam int PW = $clog2(PHYS_REGS),
  localparam int CW = $clog2(NUM_CKPT),
  localparam int DW = DISPATCH_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [DW-1:0][AW-1:0]        rs1_arch_i,
  input  logic [DW-1:0][AW-1:0]        rs2_arch_i,
  output logic [DW-1:0][PW-1:0]        rs1_phys_o,
  output logic [DW-1:0][PW-1:0]        rs2_phys_o,
  output logic [DW-1:0]                rs1_ready_o,
  output logic [DW-1:0]                rs2_ready_o,
  input  logic [DW-1:0]                disp_valid_i,
  input  logic [DW-1:0][AW-1:0]        disp_arch_i,
  input  logic [DW-1:0][PW-1:0]        disp_new_phys_i,
  output logic [DW-1:0][PW-1:0]        disp_old_phys_o,
  input  logic [DW-1:0]                is_branch_i,
  output logic [CW-1:0]                ckpt_id_o,
  output logic                         stall_o,
  input  logic [WB_WIDTH-1:0]          wb_valid_i,
  input  logic [WB_WIDTH-1:0][PW-1:0]  wb_phys_i,
  input  logic                         br_commit_i,
  input  logic                         br_mispredict_i,
  input  logic [CW-1:0]                br_ckpt_id_i,
  input  logic                         flush_i,
  output logic [CW:0]                  ckpt_count_o
);
  logic [ARCH_REGS-1:0][PW-1:0] r_map, w_next_map, w_ckpt_map, w_rd_map;
  logic [PHYS_REGS-1:0]         r_ready, w_next_ready;
  logic [DW-1:0]                w_br;
  logic                         w_do_disp, w_ckpt_wr;

  function automatic logic wb_hit(input logic [PW-1:0] t,
                                  input logic [WB_WIDTH-1:0] v,
                                  input logic [WB_WIDTH-1:0][PW-1:0] p);
    wb_hit = 1'b0;
    for (int w = 0; w < WB_WIDTH; w++)
      if (v[w] && p[w] == t) wb_hit = 1'b1;
  endfunction

  assign w_br      = is_branch_i & disp_valid_i;
  assign stall_o   = (|w_br) && (ckpt_count_o == (CW+1)'(NUM_CKPT));
  assign w_do_disp = !stall_o && !br_mispredict_i && !flush_i;
  assign w_ckpt_wr = w_do_disp && (|w_br);

  // Older slots bypass their new tags to younger slots; the last match is the youngest.
  for (genvar k = 0; k < DW; k++) begin : g_slot
    logic [PW-1:0] w_p1, w_p2, w_old;
    logic          w_r1, w_r2;
    always_comb begin
      w_p1  = r_map[rs1_arch_i[k]];
      w_p2  = r_map[rs2_arch_i[k]];
      w_old = r_map[disp_arch_i[k]];
      w_r1  = r_ready[w_p1] | wb_hit(w_p1, wb_valid_i, wb_phys_i);
      w_r2  = r_ready[w_p2] | wb_hit(w_p2, wb_valid_i, wb_phys_i);
      for (int j = 0; j < k; j++) begin
        if (disp_valid_i[j] && disp_arch_i[j] == rs1_arch_i[k]) begin
          w_p1 = disp_new_phys_i[j];
          w_r1 = 1'b0;
        end
        if (disp_valid_i[j] && disp_arch_i[j] == rs2_arch_i[k]) begin
          w_p2 = disp_new_phys_i[j];
          w_r2 = 1'b0;
        end
        if (disp_valid_i[j] && disp_arch_i[j] == disp_arch_i[k])
          w_old = disp_new_phys_i[j];
      end
      if (rs1_arch_i[k] == '0) begin
        w_p1 = '0;
        w_r1 = 1'b1;
      end
      if (rs2_arch_i[k] == '0) begin
        w_p2 = '0;
        w_r2 = 1'b1;
      end
      if (disp_arch_i[k] == '0) w_old = '0;
    end
    assign rs1_phys_o[k]      = w_p1;
    assign rs2_phys_o[k]      = w_p2;
    assign rs1_ready_o[k]     = w_r1;
    assign rs2_ready_o[k]     = w_r2;
    assign disp_old_phys_o[k] = w_old;
  end

  // Checkpoint snapshot is the map after the branch slot's own rename.
  always_comb begin
    w_next_map = r_map;
    w_ckpt_map = r_map;
    for (int k = 0; k < DW; k++) begin
      if (disp_valid_i[k] && disp_arch_i[k] != '0)
        w_next_map[disp_arch_i[k]] = disp_new_phys_i[k];
      if (w_br[k]) w_ckpt_map = w_next_map;
    end
  end

  always_comb begin
    w_next_ready = r_ready;
    for (int w = 0; w < WB_WIDTH; w++)
      if (wb_valid_i[w]) w_next_ready[wb_phys_i[w]] = 1'b1;
    if (w_do_disp)
      for (int k = 0; k < DW; k++)
        if (disp_valid_i[k] && disp_arch_i[k] != '0)
          w_next_ready[disp_new_phys_i[k]] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      for (int i = 0; i < ARCH_REGS; i++) r_map[i] <= PW'(i);
      r_ready <= '1;
    end else begin
      if (br_mispredict_i) r_map <= w_rd_map;
      else if (w_do_disp)  r_map <= w_next_map;
      r_ready <= w_next_ready;
    end
  end

  rat_ckpt_store #(
    .ARCH_REGS (ARCH_REGS),
    .PHYS_REGS (PHYS_REGS),
    .NUM_CKPT  (NUM_CKPT)
  ) u_store (
    .clock        (clock),
    .reset        (reset),
    .i_flush      (flush_i),
    .i_wr_en      (w_ckpt_wr),
    .i_wr_map     (w_ckpt_map),
    .i_commit     (br_commit_i),
    .i_restore    (br_mispredict_i && !flush_i),
    .i_restore_id (br_ckpt_id_i),
    .o_rd_map     (w_rd_map),
    .o_tail       (ckpt_id_o),
    .o_count      (ckpt_count_o)
  );
endmodule

// File: tb/tb_rat_ckpt.sv
// Directed bench for rat_ckpt: lookup/bypass, ready tracking, checkpoint queue, restore and flush.
module tb_rat_ckpt;
  logic            clock = 1'b0;
  logic            reset;
  logic [1:0][4:0] rs1_arch, rs2_arch, disp_arch;
  logic [1:0][5:0] rs1_phys, rs2_phys, disp_new, disp_old;
  logic [1:0]      rs1_rdy, rs2_rdy, disp_valid, is_branch;
  logic [1:0]      ckpt_id;
  logic            stall;
  logic [3:0]      wb_valid;
  logic [3:0][5:0] wb_phys;
  logic            br_commit, br_mispredict, flush;
  logic [1:0]      br_id;
  logic [2:0]      count;
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  rat_ckpt dut (
    .clock(clock), .reset(reset),
    .rs1_arch_i(rs1_arch), .rs2_arch_i(rs2_arch),
    .rs1_phys_o(rs1_phys), .rs2_phys_o(rs2_phys),
    .rs1_ready_o(rs1_rdy), .rs2_ready_o(rs2_rdy),
    .disp_valid_i(disp_valid), .disp_arch_i(disp_arch),
    .disp_new_phys_i(disp_new), .disp_old_phys_o(disp_old),
    .is_branch_i(is_branch), .ckpt_id_o(ckpt_id), .stall_o(stall),
    .wb_valid_i(wb_valid), .wb_phys_i(wb_phys),
    .br_commit_i(br_commit), .br_mispredict_i(br_mispredict),
    .br_ckpt_id_i(br_id), .flush_i(flush), .ckpt_count_o(count)
  );

  task automatic idle();
    rs1_arch = '0; rs2_arch = '0; disp_arch = '0; disp_new = '0;
    disp_valid = '0; is_branch = '0; wb_valid = '0; wb_phys = '0;
    br_commit = 0; br_mispredict = 0; flush = 0; br_id = '0;
  endtask

  task automatic test_reset();
    idle(); reset = 1;
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 0;
    rs1_arch[0] = 5'd5; rs2_arch[1] = 5'd0;
    #1;
    checks++; if (rs1_phys[0] !== 6'd5) begin failures++; $display("FAIL reset_lookup got=%0d exp=5", rs1_phys[0]); end
    checks++; if (rs1_rdy[0] !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", rs1_rdy[0]); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    checks++; if (rs2_phys[1] !== 6'd0 || rs2_rdy[1] !== 1'b1) begin failures++; $display("FAIL reset_r0 got=%0d/%0b exp=0/1", rs2_phys[1], rs2_rdy[1]); end
  endtask

  task automatic test_bypass();
    @(negedge clock); idle();
    disp_valid = 2'b11; disp_arch[0] = 5'd3; disp_new[0] = 6'd40;
    disp_arch[1] = 5'd3; disp_new[1] = 6'd41; rs1_arch[1] = 5'd3; rs1_arch[0] = 5'd3;
    #1;
    checks++; if (rs1_phys[1] !== 6'd40 || rs1_rdy[1] !== 1'b0) begin failures++; $display("FAIL bypass_rs1 got=%0d/%0b exp=40/0", rs1_phys[1], rs1_rdy[1]); end
    checks++; if (rs1_phys[0] !== 6'd3 || rs1_rdy[0] !== 1'b1) begin failures++; $display("FAIL bypass_slot0 got=%0d/%0b exp=3/1", rs1_phys[0], rs1_rdy[0]); end
    checks++; if (disp_old[0] !== 6'd3 || disp_old[1] !== 6'd40) begin failures++; $display("FAIL bypass_old got=%0d,%0d exp=3,40", disp_old[0], disp_old[1]); end
    @(negedge clock); idle(); rs1_arch[0] = 5'd3;
    #1;
    checks++; if (rs1_phys[0] !== 6'd41 || rs1_rdy[0] !== 1'b0) begin failures++; $display("FAIL bypass_next got=%0d/%0b exp=41/0", rs1_phys[0], rs1_rdy[0]); end
  endtask

  task automatic test_wb();
    @(negedge clock); idle(); rs1_arch[0] = 5'd3;
    wb_valid[1] = 1'b1; wb_phys[1] = 6'd41;
    #1;
    checks++; if (rs1_phys[0] !== 6'd41 || rs1_rdy[0] !== 1'b1) begin failures++; $display("FAIL wb_forward got=%0d/%0b exp=41/1", rs1_phys[0], rs1_rdy[0]); end
    @(negedge clock); idle(); rs1_arch[0] = 5'd3;
    #1;
    checks++; if (rs1_rdy[0] !== 1'b1) begin failures++; $display("FAIL wb_state got=%0b exp=1", rs1_rdy[0]); end
  endtask

  task automatic test_branch();
    @(negedge clock); idle();
    disp_valid = 2'b11; is_branch = 2'b01;
    disp_arch[0] = 5'd4; disp_new[0] = 6'd50; disp_arch[1] = 5'd4; disp_new[1] = 6'd51;
    #1;
    checks++; if (ckpt_id !== 2'd0 || stall !== 1'b0) begin failures++; $display("FAIL br_id got=%0d/%0b exp=0/0", ckpt_id, stall); end
    @(negedge clock); idle(); rs1_arch[0] = 5'd4;
    #1;
    checks++; if (rs1_phys[0] !== 6'd51 || count !== 3'd1) begin failures++; $display("FAIL br_map got=%0d/%0d exp=51/1", rs1_phys[0], count); end
    br_mispredict = 1; br_id = 2'd0;
    @(negedge clock); idle(); rs1_arch[0] = 5'd4; rs2_arch[0] = 5'd3;
    #1;
    checks++; if (rs1_phys[0] !== 6'd50 || rs1_rdy[0] !== 1'b0) begin failures++; $display("FAIL br_restore got=%0d/%0b exp=50/0", rs1_phys[0], rs1_rdy[0]); end
    checks++; if (count !== 3'd1 || ckpt_id !== 2'd1) begin failures++; $display("FAIL br_restore_cnt got=%0d/%0d exp=1/1", count, ckpt_id); end
    checks++; if (rs2_phys[0] !== 6'd41) begin failures++; $display("FAIL br_restore_r3 got=%0d exp=41", rs2_phys[0]); end
  endtask

  task automatic test_full_stall();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); idle();
      disp_valid[0] = 1'b1; is_branch[0] = 1'b1;
      disp_arch[0] = 5'(6 + i); disp_new[0] = 6'(20 + i);
      #1;
      checks++; if (ckpt_id !== 2'(1 + i)) begin failures++; $display("FAIL fill_id%0d got=%0d exp=%0d", i, ckpt_id, 1 + i); end
    end
    @(negedge clock); idle();
    disp_valid[0] = 1'b1; is_branch[0] = 1'b1; disp_arch[0] = 5'd9; disp_new[0] = 6'd30;
    br_commit = 1;
    #1;
    checks++; if (stall !== 1'b1 || count !== 3'd4) begin failures++; $display("FAIL full_stall got=%0b/%0d exp=1/4", stall, count); end
    @(negedge clock); br_commit = 0; rs1_arch[0] = 5'd9;
    #1;
    checks++; if (rs1_phys[0] !== 6'd9 || count !== 3'd3) begin failures++; $display("FAIL stall_nomap got=%0d/%0d exp=9/3", rs1_phys[0], count); end
    checks++; if (stall !== 1'b0 || ckpt_id !== 2'd0) begin failures++; $display("FAIL wrap_id got=%0b/%0d exp=0/0", stall, ckpt_id); end
    @(negedge clock); idle(); rs1_arch[0] = 5'd9;
    #1;
    checks++; if (rs1_phys[0] !== 6'd30 || count !== 3'd4) begin failures++; $display("FAIL wrap_accept got=%0d/%0d exp=30/4", rs1_phys[0], count); end
  endtask

  task automatic test_mispredict_drop();
    @(negedge clock); idle();
    br_mispredict = 1; br_id = 2'd2;
    disp_valid[0] = 1'b1; disp_arch[0] = 5'd10; disp_new[0] = 6'd45;
    @(negedge clock); idle();
    rs1_arch[0] = 5'd10; rs2_arch[0] = 5'd8; rs1_arch[1] = 5'd7; rs2_arch[1] = 5'd9;
    #1;
    checks++; if (rs1_phys[0] !== 6'd10) begin failures++; $display("FAIL drop_disp got=%0d exp=10", rs1_phys[0]); end
    checks++; if (rs2_phys[0] !== 6'd8 || rs1_phys[1] !== 6'd21 || rs2_phys[1] !== 6'd9) begin failures++; $display("FAIL drop_map got=%0d,%0d,%0d exp=8,21,9", rs2_phys[0], rs1_phys[1], rs2_phys[1]); end
    checks++; if (count !== 3'd2 || ckpt_id !== 2'd3) begin failures++; $display("FAIL drop_cnt got=%0d/%0d exp=2/3", count, ckpt_id); end
    br_mispredict = 1; br_id = 2'd2; br_commit = 1;
    @(negedge clock); idle(); rs1_arch[1] = 5'd7;
    #1;
    checks++; if (count !== 3'd1 || rs1_phys[1] !== 6'd21) begin failures++; $display("FAIL mis_commit got=%0d/%0d exp=1/21", count, rs1_phys[1]); end
  endtask

  task automatic test_flush();
    @(negedge clock); idle();
    flush = 1; disp_valid[0] = 1'b1; disp_arch[0] = 5'd11; disp_new[0] = 6'd46;
    @(negedge clock); idle();
    rs1_arch[0] = 5'd7; rs2_arch[0] = 5'd11; rs1_arch[1] = 5'd4;
    #1;
    checks++; if (rs1_phys[0] !== 6'd7 || rs2_phys[0] !== 6'd11) begin failures++; $display("FAIL flush_map got=%0d,%0d exp=7,11", rs1_phys[0], rs2_phys[0]); end
    checks++; if (count !== 3'd0 || ckpt_id !== 2'd0) begin failures++; $display("FAIL flush_cnt got=%0d/%0d exp=0/0", count, ckpt_id); end
    checks++; if (rs1_phys[1] !== 6'd4 || rs1_rdy[1] !== 1'b1) begin failures++; $display("FAIL flush_ready got=%0d/%0b exp=4/1", rs1_phys[1], rs1_rdy[1]); end
  endtask

  task automatic test_back_to_back();
    @(negedge clock); idle();
    disp_valid[0] = 1'b1; disp_arch[0] = 5'd12; disp_new[0] = 6'd33;
    @(negedge clock); idle();
    rs1_arch[0] = 5'd12; rs2_arch[1] = 5'd12;
    disp_valid[0] = 1'b1; disp_arch[0] = 5'd12; disp_new[0] = 6'd34;
    wb_valid[3] = 1'b1; wb_phys[3] = 6'd33;
    #1;
    checks++; if (rs1_phys[0] !== 6'd33 || rs1_rdy[0] !== 1'b1) begin failures++; $display("FAIL b2b_rs1 got=%0d/%0b exp=33/1", rs1_phys[0], rs1_rdy[0]); end
    checks++; if (rs2_phys[1] !== 6'd34 || rs2_rdy[1] !== 1'b0) begin failures++; $display("FAIL b2b_rs2 got=%0d/%0b exp=34/0", rs2_phys[1], rs2_rdy[1]); end
    checks++; if (disp_old[0] !== 6'd33) begin failures++; $display("FAIL b2b_old got=%0d exp=33", disp_old[0]); end
    @(negedge clock); idle();
    rs1_arch[0] = 5'd12; rs1_arch[1] = 5'd0;
    disp_valid[1] = 1'b1; disp_arch[1] = 5'd0; disp_new[1] = 6'd60;
    #1;
    checks++; if (rs1_phys[0] !== 6'd34 || rs1_rdy[0] !== 1'b0) begin failures++; $display("FAIL b2b_next got=%0d/%0b exp=34/0", rs1_phys[0], rs1_rdy[0]); end
    checks++; if (disp_old[1] !== 6'd0 || rs1_phys[1] !== 6'd0 || rs1_rdy[1] !== 1'b1) begin failures++; $display("FAIL r0_disp got=%0d,%0d/%0b exp=0,0/1", disp_old[1], rs1_phys[1], rs1_rdy[1]); end
    wb_valid[2] = 1'b1; wb_phys[2] = 6'd34;
    #1;
    checks++; if (rs1_rdy[0] !== 1'b1) begin failures++; $display("FAIL b2b_wb got=%0b exp=1", rs1_rdy[0]); end
    @(negedge clock); idle(); rs1_arch[1] = 5'd0;
    #1;
    checks++; if (rs1_phys[1] !== 6'd0 || rs1_rdy[1] !== 1'b1) begin failures++; $display("FAIL r0_keep got=%0d/%0b exp=0/1", rs1_phys[1], rs1_rdy[1]); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_wb();
    test_branch();
    test_full_stall();
    test_mispredict_drop();
    test_flush();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
